rvc_fetch_aligner: RTL and testbench
====================================

RVC_FETCH_ALIGNER -- requirements
Module: rvc_fetch_aligner

Interface
REQ-001 Parameter: RESET_VECTOR, 32'h0, byte address of the first instruction after reset; bit 0 ignored.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: flush  input  1  redirect request from the pipeline (branch, jump or trap).
REQ-005 Port: flush_pc  input  32  redirect target; bit 0 ignored.
REQ-006 Port: mem_req  output  1  instruction-word read request to IMEM.
REQ-007 Port: mem_addr  output  32  word-aligned read address; bits [1:0] always 0.
REQ-008 Port: mem_rvalid  input  1  read data valid; arrives exactly one cycle after an accepted mem_req.
REQ-009 Port: mem_rdata  input  32  read word, little-endian (halfword 0 = bits [15:0]).
REQ-010 Port: out_valid  output  1  out_instr, out_pc and out_compressed hold a complete instruction.
REQ-011 Port: out_ready  input  1  decode stage accepts the instruction this cycle.
REQ-012 Port: out_instr  output  32  raw instruction; a 16-bit instruction is zero-extended.
REQ-013 Port: out_pc  output  32  byte address of out_instr; bit 0 always 0.
REQ-014 Port: out_compressed  output  1  out_instr is a 16-bit RVC encoding.

Function
REQ-015 Halfword queue: 4 entries x 16 bits, count 0..4; head entry at address out_pc.
REQ-016 At most one read outstanding; mem_req = !outstanding && count <= 2 && !flush; an accepted request sets outstanding for one cycle.
REQ-017 Fetch address advances by 4 after each issued request; it wraps at 32'hFFFF_FFFC -> 0.
REQ-018 On mem_rvalid: if the discard flag is clear, push halfword 0 then halfword 1; if drop_low is set, push only halfword 1 and clear drop_low.
REQ-019 Head classification: head[1:0] != 2'b11 -> compressed (needs 1 entry); head[1:0] == 2'b11 -> 32-bit (needs 2 entries).
REQ-020 out_valid = 1 when count >= entries needed; combinational from queue state, with no dependence on out_ready.
REQ-021 32-bit output: out_instr = {entry1, entry0}; compressed output: out_instr = {16'h0, entry0}; out_compressed driven to match.
REQ-022 Handshake (out_valid && out_ready): pop 1 or 2 entries; out_pc += 2 or 4, with 32-bit wrap.
REQ-023 Simultaneous push and pop in one cycle: new count = count - pop + push; count never exceeds 4 (guaranteed by REQ-016).
REQ-024 While out_valid = 1 and out_ready = 0, out_instr, out_pc and out_compressed hold stable.
REQ-025 Flush on a rising edge:
  - queue cleared; out_pc = {flush_pc[31:1], 1'b0};
  - fetch address = {flush_pc[31:2], 2'b00}; drop_low = flush_pc[1];
  - if a read is outstanding, set the discard flag so that response is dropped, then clear the flag.
REQ-026 Flush has priority over a same-cycle handshake and a same-cycle mem_rvalid; neither takes effect.
REQ-027 out_valid = 0 in the cycle after a flush.
REQ-028 A 32-bit instruction straddling a word boundary is emitted only after both halves are queued; no output is produced from a partial instruction.

Reset
REQ-029 reset_n low immediately forces, independent of clk:
  - count = 0, outstanding = 0, discard = 0;
  - drop_low = RESET_VECTOR[1];
  - out_pc = {RESET_VECTOR[31:1], 1'b0}; fetch address = {RESET_VECTOR[31:2], 2'b00};
  - out_valid = 0, mem_req = 0.
REQ-030 In the first cycle after reset_n rises, mem_req = 1 with mem_addr = fetch address.
REQ-031 Reset asserted mid-operation discards all queued and outstanding data; a mem_rvalid arriving after release is ignored unless a request was issued post-reset.

Verification
REQ-032 RESET_VECTOR 0, word0 = 32'h4595_4529, word1 = 32'h0000_952E, out_ready = 1 -> three outputs: (pc 0, 32'h4529, c=1), (pc 2, 32'h4595, c=1), (pc 4, 32'h952E, c=1).
REQ-033 Straddle: word0 = 32'h0513_4529, word1 = 32'h4505_0010 -> outputs:
  - (pc 0, 32'h4529, c=1);
  - (pc 2, 32'h0010_0513, c=0), valid only after word1 arrives;
  - (pc 6, 32'h4505, c=1).
REQ-034 Backpressure: out_ready = 0 for 5 cycles with count reaching 4 -> outputs held stable, mem_req = 0 while count > 2, and no halfword lost or duplicated after release.
REQ-035 Flush to 32'h0000_0102 in the cycle a read is outstanding -> stale response dropped, next mem_addr = 32'h100, first output out_pc = 32'h102 taken from the upper halfword.
REQ-036 reset_n pulsed low while count = 3 -> out_valid = 0 during reset; after release mem_addr = RESET_VECTOR and the first output out_pc = RESET_VECTOR.

Source files
------------

// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: turns a stream of 32-bit IMEM words into 16/32-bit RISC-V
// instructions through a 4-entry halfword queue, with flush redirect support.
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_compressed
);
  logic [63:0] q_q, q_d, kept;
  logic [2:0]  count_q, count_d, pop_n, cnt_after;
  logic        outstanding_q, outstanding_d, discard_q, discard_d, drop_low_q, drop_low_d;
  logic [31:0] pc_q, pc_d, fetch_q, fetch_d, push_data;
  logic        comp, fire, push;
  assign comp           = q_q[1:0] != 2'b11;
  assign out_valid      = count_q >= (comp ? 3'd1 : 3'd2);
  assign out_compressed = comp;
  assign out_instr      = comp ? {16'h0, q_q[15:0]} : q_q[31:0];
  assign out_pc         = pc_q;
  assign mem_addr       = fetch_q;
  // gating with reset_n keeps the request low while reset is held
  assign mem_req        = reset_n && !outstanding_q && count_q <= 3'd2 && !flush;
  assign fire           = out_valid && out_ready;
  assign push           = mem_rvalid && outstanding_q && !discard_q;
  always_comb begin
    pop_n         = fire ? (comp ? 3'd1 : 3'd2) : 3'd0;
    cnt_after     = count_q - pop_n;
    push_data     = drop_low_q ? {16'h0, mem_rdata[31:16]} : mem_rdata;
    kept          = (q_q >> {pop_n, 4'b0}) & ~({64{1'b1}} << {cnt_after, 4'b0});
    q_d           = push ? kept | ({32'h0, push_data} << {cnt_after, 4'b0}) : kept;
    count_d       = cnt_after + (push ? (drop_low_q ? 3'd1 : 3'd2) : 3'd0);
    drop_low_d    = drop_low_q && !push;
    pc_d          = pc_q + {28'd0, pop_n, 1'b0};
    fetch_d       = mem_req ? fetch_q + 32'd4 : fetch_q;
    outstanding_d = mem_req;
    discard_d     = 1'b0;
    if (flush) begin
      q_d           = '0;
      count_d       = '0;
      pc_d          = {flush_pc[31:1], 1'b0};
      fetch_d       = {flush_pc[31:2], 2'b00};
      drop_low_d    = flush_pc[1];
      discard_d     = outstanding_q;
      outstanding_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q           <= '0;
      count_q       <= '0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      drop_low_q    <= RESET_VECTOR[1];
      pc_q          <= {RESET_VECTOR[31:1], 1'b0};
      fetch_q       <= {RESET_VECTOR[31:2], 2'b00};
    end else begin
      q_q           <= q_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      drop_low_q    <= drop_low_d;
      pc_q          <= pc_d;
      fetch_q       <= fetch_d;
    end
  end
endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// tb_rvc_fetch_aligner: directed checks of the fetch aligner against a small
// one-cycle-latency IMEM model and hand-computed instruction sequences.
module tb_rvc_fetch_aligner;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_compressed;
  int compared = 0;
  int mismatched = 0;
  logic [31:0] mem [128];
  logic        rsp_req;
  logic [31:0] rsp_addr;
  logic [64:0] cap [$];

  rvc_fetch_aligner #(.RESET_VECTOR(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .flush_pc(flush_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_compressed(out_compressed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rsp_req  = mem_req;
    rsp_addr = mem_addr;
    #1;
    mem_rvalid = rsp_req;
    mem_rdata  = rsp_req ? mem[rsp_addr[8:2]] : 32'h0;
  end

  always @(posedge clk)
    if (reset_n && out_valid && out_ready && !flush)
      cap.push_back({out_pc, out_instr, out_compressed});

  task automatic init_mem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  task automatic start(input logic rdy);
    reset_n = 1'b0; flush = 1'b0; out_ready = rdy;
    repeat (2) @(negedge clk);
    cap.delete();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    init_mem();
    reset_n = 1'b0;
    @(negedge clk);
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid got %b want 0", out_valid); end
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got %b want 0", mem_req); end
    if (out_pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc got %h want 0", out_pc); end
    start(1'b0);
    #1;
    compared += 2;
    if (mem_req !== 1'b1) begin mismatched++; $display("FAIL first_req got %b want 1", mem_req); end
    if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL first_addr got %h want 0", mem_addr); end
  endtask

  task automatic test_basic();
    logic [64:0] exp [3];
    exp = '{{32'h0, 32'h4529, 1'b1}, {32'h2, 32'h4595, 1'b1}, {32'h4, 32'h952E, 1'b1}};
    init_mem();
    mem[0] = 32'h4595_4529; mem[1] = 32'h0000_952E;
    start(1'b1);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= cap.size()) begin mismatched++; $display("FAIL basic_%0d got none want %h", i, exp[i]); end
      else if (cap[i] !== exp[i]) begin mismatched++; $display("FAIL basic_%0d got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_straddle();
    logic [64:0] exp [3];
    logic seen;
    exp = '{{32'h0, 32'h4529, 1'b1}, {32'h2, 32'h0010_0513, 1'b0}, {32'h6, 32'h4505, 1'b1}};
    init_mem();
    mem[0] = 32'h0513_4529; mem[1] = 32'h4505_0010;
    seen = 1'b0;
    start(1'b1);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (!seen && out_pc == 32'h2) begin
        seen = 1'b1;
        compared++;
        if (out_valid !== 1'b0) begin mismatched++; $display("FAIL straddle_partial got %b want 0", out_valid); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (i >= cap.size()) begin mismatched++; $display("FAIL straddle_%0d got none want %h", i, exp[i]); end
      else if (cap[i] !== exp[i]) begin mismatched++; $display("FAIL straddle_%0d got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [64:0] exp [6];
    exp = '{{32'h0, 32'h4529, 1'b1}, {32'h2, 32'h4595, 1'b1}, {32'h4, 32'h952E, 1'b1},
            {32'h6, 32'h0000, 1'b1}, {32'h8, 32'h2222, 1'b1}, {32'hA, 32'h1111, 1'b1}};
    init_mem();
    mem[0] = 32'h4595_4529; mem[1] = 32'h0000_952E; mem[2] = 32'h1111_2222;
    start(1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        compared++;
        if ({out_valid, out_pc, out_instr, out_compressed} !== {1'b1, 32'h0, 32'h4529, 1'b1}) begin
          mismatched++;
          $display("FAIL hold_%0d got v=%b pc=%h i=%h c=%b want v=1 pc=0 i=4529 c=1", k, out_valid, out_pc, out_instr, out_compressed);
        end
      end
      if (k >= 4) begin
        compared++;
        if (mem_req !== 1'b0) begin mismatched++; $display("FAIL full_req_%0d got %b want 0", k, mem_req); end
      end
    end
    out_ready = 1'b1;
    repeat (14) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      compared++;
      if (i >= cap.size()) begin mismatched++; $display("FAIL bp_%0d got none want %h", i, exp[i]); end
      else if (cap[i] !== exp[i]) begin mismatched++; $display("FAIL bp_%0d got %h want %h", i, cap[i], exp[i]); end
    end
  endtask

  task automatic test_flush();
    init_mem();
    mem[0] = 32'hBEEF_BEEF; mem[64] = 32'h4505_4529;
    start(1'b1);
    @(negedge clk);
    flush = 1'b1; flush_pc = 32'h0000_0102;
    #1;
    compared++;
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL flush_req got %b want 0", mem_req); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL post_flush_valid got %b want 0", out_valid); end
    if (mem_req !== 1'b1) begin mismatched++; $display("FAIL post_flush_req got %b want 1", mem_req); end
    if (mem_addr !== 32'h100) begin mismatched++; $display("FAIL post_flush_addr got %h want 100", mem_addr); end
    repeat (8) @(negedge clk);
    compared++;
    if (cap.size() == 0) begin mismatched++; $display("FAIL flush_first got none want 102/4505"); end
    else if (cap[0] !== {32'h102, 32'h4505, 1'b1}) begin mismatched++; $display("FAIL flush_first got %h want %h", cap[0], {32'h102, 32'h4505, 1'b1}); end
  endtask

  task automatic test_mid_reset();
    init_mem();
    mem[0] = 32'h4595_4529; mem[1] = 32'h0000_952E;
    start(1'b0);
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    compared += 3;
    if (out_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    if (mem_req !== 1'b0) begin mismatched++; $display("FAIL midrst_req got %b want 0", mem_req); end
    if (out_pc !== 32'h0) begin mismatched++; $display("FAIL midrst_pc got %h want 0", out_pc); end
    start(1'b1);
    #1;
    compared += 2;
    if (mem_req !== 1'b1) begin mismatched++; $display("FAIL midrst_rel_req got %b want 1", mem_req); end
    if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL midrst_rel_addr got %h want 0", mem_addr); end
    repeat (8) @(negedge clk);
    compared++;
    if (cap.size() == 0) begin mismatched++; $display("FAIL midrst_first got none want 0/4529"); end
    else if (cap[0] !== {32'h0, 32'h4529, 1'b1}) begin mismatched++; $display("FAIL midrst_first got %h want %h", cap[0], {32'h0, 32'h4529, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_straddle();
    test_backpressure();
    test_flush();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
